alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Keeps the same 4-bit op encoding and the {N,Z,C,V} flag order.
- Adds WIDTH generalisation, a registered output, and iterative multiply/divide.
- Sits between the instruction issue stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 32: operand/result width. Must be a multiple of 8 and at least 8.
- CNT_W, $clog2(WIDTH)+1: width of the iteration counter. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block accepts an op this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_control  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- alu_flags  out  4  {N,Z,C,V}, registered.
- busy  out  1  high in CALC state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, out_valid=0, result=0, alu_flags=0, busy=0, counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: iterative mul/div in progress.
  - DONE: out_valid=1.
- Accept: an op is accepted when in_valid && in_ready on a posedge. a, b and alu_control are captured into internal registers; later input changes are ignored.
- Single-cycle ops: all opcodes except 0010/0011 go IDLE->DONE. out_valid rises on the edge after accept (latency 1).
- Iterative ops:
  - 0010 mul: shift-add. 0011 div: restoring, unsigned.
  - Both go IDLE->CALC for exactly WIDTH cycles, then DONE.
  - out_valid rises WIDTH+1 edges after accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A back-to-back accept in DONE loads the new op in the same edge that retires the old one.
- DONE->IDLE on out_ready with no new accept.
- result and alu_flags hold stable while out_valid && !out_ready.
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 mul: low WIDTH bits.
  - 0011 div
  - 0100 or
  - 0101 and
  - 0110 not A
  - 0111 nor
  - 1000 nand
  - 1001 xor
  - 1010 xnor
  - 1011 asr: shift count = b; b >= WIDTH gives an all-sign-bit result.
  - 1100 rotl: by b mod WIDTH.
  - 1101 rotr: by b mod WIDTH.
  - 1110/1111: see Optional Feature.
- Flags, all ops:
  - N = result[WIDTH-1].
  - Z = (result==0).
- Flags, add: C = carry-out; V = signed overflow.
- Flags, sub: C = borrow (a<b unsigned); V = signed overflow.
- Flags, mul: V = upper WIDTH bits of the full product nonzero; C=0.
- Flags, div: C=0, V=0.
- Div by zero: result all ones, V=1, C=0. Still takes WIDTH cycles.
- Flags, logic/shift/rotate ops: C=0, V=0.
- Rotate by 0: result = a.
- Reset mid-CALC or mid-DONE: the operation is aborted with no output; all registers take reset values on that edge.
- in_valid during CALC is ignored (in_ready=0). No op is lost, because the producer holds the request until in_ready.

Optional Feature:
- Macro: ALU_SIMD_EN.
- Defined: ops 1110/1111 are packed lane-wise 8-bit unsigned add/mul over WIDTH/8 lanes, single-cycle. Each lane result is truncated to 8 bits.
  - 1110 add: C = OR of lane carry-outs; V = C.
  - 1111 mul: V = OR over lanes of (lane product > 255); C=0.
  - N = OR of lane MSBs.
  - Z = all lanes zero.
- Undefined: 1110/1111 complete single-cycle with result=0 and alu_flags=4'b0100.

Test Plan:
- WIDTH=32, add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, flags 0110, out_valid exactly 1 edge after accept.
- sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, flags 0001.
- sub 0x00000001 - 0x00000002 -> result 0xFFFFFFFF, flags 1010.
- div 100/7 -> result 14, flags 0000, out_valid 33 edges after accept, busy high for 32 cycles.
- div 5/0 -> result 0xFFFFFFFF, flags 1001.
- mul 0x00010000 * 0x00010000 -> result 0, flags 0101.
- mul 3*5 -> result 15, flags 0000.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> result/flags stable, in_ready=0. Then raise out_ready with in_valid=1 (xor 0xF0F0F0F0, 0xFFFFFFFF) -> new result 0x0F0F0F0F, out_valid high on the next edge with no bubble.
- Reset abort: drop rst_n for one cycle at CALC cycle 10 of a div -> next edge out_valid=0, busy=0, result=0, in_ready=1. A following rotl 0x80000001 by 33 returns 0x00000003, flags 0000.
- ALU_SIMD_EN defined: uadd a=0x80FF0102, b=0x80010203 -> result 0x00000305, flags 0011.
- ALU_SIMD_EN undefined: same stimulus -> result 0, flags 0100.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative mul/div; optional SIMD lanes under ALU_SIMD_EN
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0]       OP_MUL   = 4'b0010;
  localparam logic [3:0]       OP_DIV   = 4'b0011;
  localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;

  logic               accept;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic [WIDTH-1:0]   rot_amt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_n;
  logic               sc_c;
  logic               sc_v;
  logic               is_iter;

`ifdef ALU_SIMD_EN
  logic [8:0]         lane_sum;
  logic [15:0]        lane_prod;
`endif

  // Iterative datapath: one shift-add or restoring-divide step per CALC cycle
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic [WIDTH-1:0]   it_res;
  logic               it_v;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign result    = result_q;
  assign alu_flags = flags_q;
  assign is_iter   = (alu_control == OP_MUL) || (alu_control == OP_DIV);

  // Single-cycle op result and flags from the presented operands
  always_comb begin
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;
    rot_amt  = b % W_VAL;
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
`ifdef ALU_SIMD_EN
    lane_sum  = '0;
    lane_prod = '0;
`endif
    case (alu_control)
      4'b0000: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        sc_res = sub_diff;
        sc_c   = (a < b);
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0100: sc_res = a | b;
      4'b0101: sc_res = a & b;
      4'b0110: sc_res = ~a;
      4'b0111: sc_res = ~(a | b);
      4'b1000: sc_res = ~(a & b);
      4'b1001: sc_res = a ^ b;
      4'b1010: sc_res = ~(a ^ b);
      4'b1011: begin
        // Oversized shift counts saturate to a full sign fill
        if (b >= W_VAL) begin
          sc_res = {WIDTH{a[WIDTH-1]}};
        end else begin
          sc_res = $signed(a) >>> b;
        end
      end
      // A zero rotate makes the complementary shift equal WIDTH, which yields 0
      4'b1100: sc_res = (a << rot_amt) | (a >> (W_VAL - rot_amt));
      4'b1101: sc_res = (a >> rot_amt) | (a << (W_VAL - rot_amt));
`ifdef ALU_SIMD_EN
      4'b1110: begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          lane_sum = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
          sc_res[8*i +: 8] = lane_sum[7:0];
          sc_c = sc_c | lane_sum[8];
        end
        sc_v = sc_c;
      end
      4'b1111: begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          lane_prod = {8'b0, a[8*i +: 8]} * {8'b0, b[8*i +: 8]};
          sc_res[8*i +: 8] = lane_prod[7:0];
          sc_v = sc_v | (|lane_prod[15:8]);
        end
      end
`endif
      default: sc_res = '0;
    endcase

    sc_n = sc_res[WIDTH-1];
`ifdef ALU_SIMD_EN
    // Packed ops report a negative flag if any lane's top bit is set
    if (alu_control == 4'b1110 || alu_control == 4'b1111) begin
      sc_n = 1'b0;
      for (int i = 0; i < WIDTH / 8; i++) begin
        sc_n = sc_n | sc_res[8*i + 7];
      end
    end
`endif
  end

  // One iteration step; hi/lo hold {product} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    it_hi     = '0;
    it_lo     = '0;
    it_res    = '0;
    it_v      = 1'b0;
    if (op_q == OP_MUL) begin
      it_hi  = mul_sum[WIDTH:1];
      it_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      it_res = it_lo;
      it_v   = |it_hi;
    end else begin
      it_hi  = div_ge ? div_sub : div_shift[WIDTH-1:0];
      it_lo  = {lo_q[WIDTH-2:0], div_ge};
      // Divide by zero still runs the full iteration count, then reports all ones
      it_res = (b_q == '0) ? '1 : it_lo;
      it_v   = (b_q == '0);
    end
  end

  // Next-state and register updates for the IDLE/CALC/DONE controller
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d  = a;
          b_d  = b;
          op_d = alu_control;
          if (is_iter) begin
            state_d = S_CALC;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = (alu_control == OP_MUL) ? b : a;
          end else begin
            state_d  = S_DONE;
            result_d = sc_res;
            flags_d  = {sc_n, (sc_res == '0), sc_c, sc_v};
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = it_res;
          flags_d  = {it_res[WIDTH-1], (it_res == '0), 1'b0, it_v};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=32), honours ALU_SIMD_EN
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  alu_flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model straight from the opcode rules, using 64-bit arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f);
    logic [63:0] wide;
    longint      s;
    logic        n, c, v;
    int          sh;
    logic [7:0]  la, lb;
    int          lsum, lprod;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        wide = {32'b0, x} + {32'b0, y};
        r = wide[31:0]; c = wide[32];
        s = longint'($signed(x)) + longint'($signed(y)); v = ovf32(s);
      end
      4'd1: begin
        r = x - y; c = (x < y);
        s = longint'($signed(x)) - longint'($signed(y)); v = ovf32(s);
      end
      4'd2: begin
        wide = {32'b0, x} * {32'b0, y};
        r = wide[31:0]; v = (wide[63:32] != 0);
      end
      4'd3: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
        else r = x / y;
      end
      4'd4:  r = x | y;
      4'd5:  r = x & y;
      4'd6:  r = ~x;
      4'd7:  r = ~(x | y);
      4'd8:  r = ~(x & y);
      4'd9:  r = x ^ y;
      4'd10: r = ~(x ^ y);
      4'd11: begin
        if (y >= 32) r = x[31] ? 32'hFFFF_FFFF : 32'h0;
        else begin
          s = longint'($signed(x)) >>> y;
          r = s[31:0];
        end
      end
      4'd12: begin sh = int'(y % 32); wide = {x, x} << sh; r = wide[63:32]; end
      4'd13: begin sh = int'(y % 32); wide = {x, x} >> sh; r = wide[31:0]; end
      default: begin
`ifdef ALU_SIMD_EN
        for (int i = 0; i < 4; i++) begin
          la = x[8*i +: 8]; lb = y[8*i +: 8];
          lsum = int'(la) + int'(lb);
          lprod = int'(la) * int'(lb);
          if (op == 4'd14) begin
            r[8*i +: 8] = lsum[7:0];
            if (lsum > 255) c = 1'b1;
          end else begin
            r[8*i +: 8] = lprod[7:0];
            if (lprod > 255) v = 1'b1;
          end
        end
        if (op == 4'd14) v = c;
`else
        la = 8'd0; lb = 8'd0; lsum = 0; lprod = 0;
`endif
      end
    endcase
    n = r[31];
`ifdef ALU_SIMD_EN
    if (op >= 4'd14) n = r[31] | r[23] | r[15] | r[7];
`endif
    f = {n, (r == 0), c, v};
  endfunction

  // Issue one op from IDLE, measure latency and busy cycles, then retire it
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output int lat, output int bcnt);
    int n;
    @(negedge clk);
    alu_control = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; bcnt = 0;
    if (busy) bcnt++;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy && !out_valid) bcnt++;
    end
    r = result; f = alu_flags;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  logic [31:0] r, er;
  logic [3:0]  f, ef;
  int          lat, bcnt, elat, ovcnt;
  logic [3:0]  rop;
  logic [31:0] rx, ry;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_control = '0;

    vt[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1};
    vt[1]  = '{4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001, 1};
    vt[2]  = '{4'h1, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b1010, 1};
    vt[3]  = '{4'h3, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
    vt[4]  = '{4'h3, 32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1001, 33};
    vt[5]  = '{4'h2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0101, 33};
    vt[6]  = '{4'h2, 32'd3,         32'd5,         32'd15,        4'b0000, 33};
    vt[7]  = '{4'hB, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000, 1};
    vt[8]  = '{4'hB, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 4'b1000, 1};
    vt[9]  = '{4'hB, 32'h7FFF_FFFF, 32'd32,        32'h0000_0000, 4'b0100, 1};
    vt[10] = '{4'hC, 32'h8000_0001, 32'd33,        32'h0000_0003, 4'b0000, 1};
    vt[11] = '{4'hD, 32'h1234_5678, 32'd0,         32'h1234_5678, 4'b0000, 1};
    vt[12] = '{4'hD, 32'h0000_0001, 32'd1,         32'h8000_0000, 4'b1000, 1};
    vt[13] = '{4'h7, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1000, 1};
    vt[14] = '{4'hA, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b0100, 1};
    vt[15] = '{4'h6, 32'h0,         32'h1234,      32'hFFFF_FFFF, 4'b1000, 1};
    vt[16] = '{4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001, 1};
    vt[17] = '{4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 33};
    vt[18] = '{4'h3, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 4'b1000, 33};
    vt[19] = '{4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", alu_flags, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 20; i++) begin
      run_op(vt[i].op, vt[i].x, vt[i].y, r, f, lat, bcnt);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_flags", i), f, vt[i].fl);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, (vt[i].lat == 33) ? 32 : 0);
    end

    // Packed-lane ops
    run_op(4'hE, 32'h80FF_0102, 32'h8001_0203, r, f, lat, bcnt);
`ifdef ALU_SIMD_EN
    chk("simd_add_result", r, 32'h0000_0305);
    chk("simd_add_flags", f, 4'b0011);
`else
    chk("simd_add_result", r, 32'h0);
    chk("simd_add_flags", f, 4'b0100);
`endif
    chk("simd_add_latency", lat, 1);
    run_op(4'hF, 32'h1002_FF00, 32'h1003_0205, r, f, lat, bcnt);
`ifdef ALU_SIMD_EN
    chk("simd_mul_result", r, 32'h0006_FE00);
    chk("simd_mul_flags", f, 4'b1001);
`else
    chk("simd_mul_result", r, 32'h0);
    chk("simd_mul_flags", f, 4'b0100);
`endif

    // Backpressure hold, then back-to-back accept while retiring
    @(negedge clk);
    alu_control = 4'h0; a = 32'd1; b = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_result", i), result, 32'd3);
      chk($sformatf("bp_hold%0d_flags", i), alu_flags, 4'b0000);
      chk($sformatf("bp_hold%0d_in_ready", i), in_ready, 1'b0);
      chk($sformatf("bp_hold%0d_valid", i), out_valid, 1'b1);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 4'h9; a = 32'hF0F0_F0F0; b = 32'hFFFF_FFFF;
    #1;
    chk("bp_in_ready_when_draining", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_result", result, 32'h0F0F_0F0F);
    chk("b2b_flags", alu_flags, 4'b0000);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_retired", out_valid, 1'b0);
    out_ready = 1'b0;

    // Reset in the middle of a divide
    @(negedge clk);
    alu_control = 4'h3; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    ovcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) ovcnt++;
    end
    chk("abort_no_output", ovcnt, 0);
    run_op(4'hC, 32'h8000_0001, 32'd33, r, f, lat, bcnt);
    chk("post_abort_rotl_result", r, 32'h0000_0003);
    chk("post_abort_rotl_flags", f, 4'b0000);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: ry = 32'($urandom_range(0, 40));
        2: ry = 32'h0;
        default: ry = $urandom & 32'hFF;
      endcase
      model(rop, rx, ry, er, ef);
      elat = (rop == 4'd2 || rop == 4'd3) ? 33 : 1;
      run_op(rop, rx, ry, r, f, lat, bcnt);
      chk($sformatf("rnd%0d_op%0d_result", i, rop), r, er);
      chk($sformatf("rnd%0d_op%0d_flags", i, rop), f, ef);
      chk($sformatf("rnd%0d_op%0d_latency", i, rop), lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
